icache_refill: RTL and testbench
================================

# icache_refill

Instruction-cache line refill unit. On an icache miss it serves the 64-byte line (16 words) from the next-line prefetch buffer when that buffer already holds the line. Otherwise it fetches the line with one 16-beat AXI INCR read burst. It sits between the icache miss path and the AXI read port, and returns a whole line plus an early critical word.

## Interface
- LINE_WORDS, 16, words per line; fixes arlen = LINE_WORDS-1 and the 4-bit beat counter
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- miss_req  in  1  icache miss, level; held until line_valid
- miss_addr  in  32  missing fetch address; stable while miss_req=1
- pf_addr  in  32  line base held by prefetch buffer
- pf_data  in  16x32  prefetch buffer line, word i = pf_data[i]
- pf_ready  in  1  prefetch buffer contents valid
- line_addr  out  32  base of returned line ({miss_addr[31:6],6'b0})
- line_data  out  16x32  returned line, registered
- line_valid  out  1  one-cycle pulse: line_data/line_addr/from_pf/line_err valid
- from_pf  out  1  line came from prefetch buffer
- line_err  out  1  some beat had rresp != 0
- crit_word  out  32  word at miss_addr[5:2]
- crit_valid  out  1  one-cycle pulse with crit_word
- arid  out  4  constant 0
- araddr  out  32  burst base
- arlen  out  8  constant 15
- arsize  out  3  constant 2
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rid  in  4  ignored
- rdata  in  32  read beat data
- rresp  in  2  beat response
- rlast  in  1  last beat
- rvalid  in  1  beat valid
- rready  out  1  beat accept

## Operation
- States: IDLE, HDSK, TRAN, DONE.
- IDLE, miss_req=1. Compute base = {miss_addr[31:6],6'b0} and latch it into line_addr. Clear line_err. Latch widx = miss_addr[5:2].
  - Prefetch hit (pf_ready=1 and pf_addr==base, full 32-bit compare): copy pf_data into line_data. Set from_pf=1, crit_word=pf_data[widx]. Go to DONE.
  - Otherwise: set from_pf=0 and go to HDSK.
- IDLE, miss_req=0: stay in IDLE; no outputs change.
- HDSK: arvalid=1, araddr=line_addr. Go to TRAN on arready=1. Do not deassert arvalid or change araddr before arready.
- TRAN: rready=1. On each rvalid beat:
  - line_data[count] <= rdata; count <= count+1.
  - Any rresp != 0 sets line_err.
  - If count==widx: crit_word <= rdata and crit_valid pulses next cycle.
  - A beat with rlast=1 ends the burst and goes to DONE.
  - Cycles with rvalid=0 hold count.
- TRAN boundary cases:
  - count is 4 bits and wraps mod 16.
  - Beats beyond 16 before rlast overwrite from word 0.
  - If rlast arrives early, unwritten words keep their old values.
- DONE: line_valid=1 for exactly one cycle. On a prefetch hit, crit_valid=1 in the same cycle. Then go to IDLE with count=0.
- The requester drops miss_req in the cycle after line_valid. A miss_req still high in IDLE starts a new refill.
- pf_data/pf_ready changing during HDSK/TRAN has no effect.
- Outside their states: arvalid=0, rready=0, araddr=0.

## Timing
- Reset values: every output is 0.
  - line_data all 0, line_addr 0, crit_word 0.
  - line_valid, crit_valid, from_pf, line_err, arvalid, rready all 0.
  - araddr 0. State IDLE, count 0.
  - Constant outputs (arid, arlen, arsize, arburst) hold their values regardless of reset.
- Prefetch hit: miss_req sampled at edge N; line_valid=1 in cycle N+1 (1-cycle latency). No AXI activity.
- AXI path:
  - arvalid=1 from cycle N+1.
  - arready at edge M gives rready=1 from M+1.
  - Last beat at edge L gives line_valid in cycle L+1.
  - Critical beat at edge C gives crit_valid in cycle C+1.
- Reset mid-burst: all state clears asynchronously. The outstanding AXI burst is not drained; interconnect reset covers it. After release, IDLE with count=0.

## Test plan
- Prefetch hit: pf_ready=1, pf_addr=0xBFC00040, pf_data[i]=i; miss_addr=0xBFC00048 -> arvalid never 1; next cycle line_valid=crit_valid=from_pf=1, line_addr=0xBFC00040, line_data[i]=i, crit_word=2.
- AXI path: pf_ready=0, miss_addr=0x00001234, arready delayed 3 cycles -> arvalid held with araddr=0x00001200, arlen=15; beats 0xA0+i -> crit_valid once with crit_word=0xAD (beat 13); line_valid one cycle after rlast, from_pf=0, line_data[i]=0xA0+i.
- Address mismatch: pf_ready=1, pf_addr=0x00001240, miss_addr=0x00001200 -> AXI burst issued, from_pf=0.
- Bubbles and error: rvalid low 2 cycles between each beat, rresp=2 on beat 5 -> count holds through gaps, all 16 words correct, line_err=1 at line_valid; next miss with clean beats -> line_err=0.
- Reset mid-burst: rst=0 after 7 beats -> all outputs 0 immediately; after release, new miss 0x2000 -> fresh burst, line_data[i] taken from the new beats starting at word 0.
- Back-to-back: miss_req held high through line_valid with a new miss_addr -> second refill starts in the IDLE cycle after DONE.

Source files
------------

// File: rtl/icache_refill_if.sv
// -----------------------------------------------------------------------------
// icache_refill_if
// AXI read-address and read-data channels used by the icache refill unit.
//   master : refill unit side (drives ar*, rready; receives arready, r*)
//   slave  : memory / interconnect side
// -----------------------------------------------------------------------------
interface icache_refill_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
// Instruction-cache line refill unit. A miss is served from the next-line
// prefetch buffer when it holds the missing line; otherwise the line is
// fetched with a single LINE_WORDS-beat AXI INCR read burst. The whole line is
// returned with a line_valid pulse, and the critical word (the one that
// missed) is returned early with a crit_valid pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   miss_req, miss_addr      level miss request and fetch address
//   pf_addr, pf_data, pf_ready  prefetch buffer line and its validity
//   line_addr, line_data     returned line base and contents (registered)
//   line_valid               one-cycle pulse, line outputs valid
//   from_pf, line_err        line source / some beat returned an error
//   crit_word, crit_valid    critical word and its one-cycle pulse
//   axi                      AXI read channels (master modport)
// -----------------------------------------------------------------------------
module icache_refill #(
    parameter int LINE_WORDS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req,
    input  logic [31:0]                  miss_addr,
    input  logic [31:0]                  pf_addr,
    input  logic [LINE_WORDS-1:0][31:0]  pf_data,
    input  logic                         pf_ready,
    output logic [31:0]                  line_addr,
    output logic [LINE_WORDS-1:0][31:0]  line_data,
    output logic                         line_valid,
    output logic                         from_pf,
    output logic                         line_err,
    output logic [31:0]                  crit_word,
    output logic                         crit_valid,
    icache_refill_if.master              axi
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, HDSK, TRAN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   widx;
    logic               crit_pend;

    logic [31:0]        miss_base;
    logic [CNT_W-1:0]   miss_widx;
    logic               pf_hit;

    assign miss_base = {miss_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign miss_widx = miss_addr[OFF_W-1:2];
    // Full 32-bit compare: the prefetch buffer only holds line-aligned bases.
    assign pf_hit    = pf_ready && (pf_addr == miss_base);

    // rid and the byte offset within the word carry no information here.
    logic unused_ok;
    assign unused_ok = &{1'b0, axi.rid, miss_addr[1:0]};

    // Fixed burst shape: one full line, 32-bit beats, incrementing.
    assign axi.arid    = 4'd0;
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = 3'd2;
    assign axi.arburst = 2'b01;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (miss_req) state_nxt = pf_hit ? DONE : HDSK;
            HDSK: if (axi.arready) state_nxt = TRAN;
            TRAN: if (axi.rvalid && axi.rlast) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        axi.arvalid = (state == HDSK);
        axi.araddr  = (state == HDSK) ? line_addr : 32'd0;
        axi.rready  = (state == TRAN);
        line_valid  = (state == DONE);
        // A prefetch hit has its critical word ready together with the line;
        // on the AXI path the pulse follows the critical beat by one cycle.
        crit_valid  = crit_pend || ((state == DONE) && from_pf);
    end

    // Line datapath and beat bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_addr <= '0;
            line_data <= '0;
            from_pf   <= 1'b0;
            line_err  <= 1'b0;
            crit_word <= '0;
            crit_pend <= 1'b0;
            count     <= '0;
            widx      <= '0;
        end else begin
            crit_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        line_addr <= miss_base;
                        line_err  <= 1'b0;
                        widx      <= miss_widx;
                        if (pf_hit) begin
                            line_data <= pf_data;
                            from_pf   <= 1'b1;
                            crit_word <= pf_data[miss_widx];
                        end else begin
                            from_pf   <= 1'b0;
                        end
                    end
                end
                TRAN: begin
                    // rready is always high in TRAN, so rvalid alone is a beat.
                    // count wraps, so overlong bursts overwrite from word 0.
                    if (axi.rvalid) begin
                        line_data[count] <= axi.rdata;
                        count            <= count + 1'b1;
                        if (axi.rresp != 2'b00) line_err <= 1'b1;
                        if (count == widx) begin
                            crit_word <= axi.rdata;
                            crit_pend <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// -----------------------------------------------------------------------------
// tb_icache_refill
// Directed bench for icache_refill. Stimulus tasks drive misses and the AXI
// slave side on a fixed schedule and keep a line-level model (expected line
// contents, error flag, source, critical word, and which pulses are due in
// the current cycle). One compare process checks the DUT against it every
// cycle; literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_icache_refill;

    logic               clk = 1'b0;
    logic               rst;
    logic               miss_req;
    logic [31:0]        miss_addr;
    logic [31:0]        pf_addr;
    logic [15:0][31:0]  pf_data;
    logic               pf_ready;
    logic [31:0]        line_addr;
    logic [15:0][31:0]  line_data;
    logic               line_valid;
    logic               from_pf;
    logic               line_err;
    logic [31:0]        crit_word;
    logic               crit_valid;

    icache_refill_if axi();

    icache_refill #(.LINE_WORDS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .pf_addr    (pf_addr),
        .pf_data    (pf_data),
        .pf_ready   (pf_ready),
        .line_addr  (line_addr),
        .line_data  (line_data),
        .line_valid (line_valid),
        .from_pf    (from_pf),
        .line_err   (line_err),
        .crit_word  (crit_word),
        .crit_valid (crit_valid),
        .axi        (axi.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] mdl_line [16];
    logic [31:0] mdl_addr;
    logic [31:0] mdl_crit;
    logic        mdl_err;
    logic        mdl_pf;
    logic        exp_lv, exp_cv, exp_arvalid, exp_rready;
    logic [31:0] exp_araddr;
    logic        chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_lv = 1'b0;
        exp_cv = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl_line[i] = 32'd0;
        mdl_addr = 0; mdl_crit = 0; mdl_err = 0; mdl_pf = 0;
        exp_lv = 0; exp_cv = 0; exp_arvalid = 0; exp_rready = 0; exp_araddr = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_line_valid"}, 32'(line_valid), 32'd0);
        chk({tag, "_crit_valid"}, 32'(crit_valid), 32'd0);
        chk({tag, "_from_pf"},    32'(from_pf),    32'd0);
        chk({tag, "_line_err"},   32'(line_err),   32'd0);
        chk({tag, "_arvalid"},    32'(axi.arvalid), 32'd0);
        chk({tag, "_rready"},     32'(axi.rready),  32'd0);
        chk({tag, "_araddr"},     axi.araddr,      32'd0);
        chk({tag, "_line_addr"},  line_addr,       32'd0);
        chk({tag, "_crit_word"},  crit_word,       32'd0);
        for (int i = 0; i < 16; i++) chk({tag, "_line_data"}, line_data[i], 32'd0);
        chk({tag, "_arlen"},      32'(axi.arlen),  32'd15);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("line_valid", 32'(line_valid),  32'(exp_lv));
            chk("crit_valid", 32'(crit_valid),  32'(exp_cv));
            chk("arvalid",    32'(axi.arvalid), 32'(exp_arvalid));
            chk("rready",     32'(axi.rready),  32'(exp_rready));
            chk("araddr",     axi.araddr,       exp_araddr);
            chk("arid",       32'(axi.arid),    32'd0);
            chk("arlen",      32'(axi.arlen),   32'd15);
            chk("arsize",     32'(axi.arsize),  32'd2);
            chk("arburst",    32'(axi.arburst), 32'd1);
            if (exp_lv) begin
                chk("line_addr", line_addr,        mdl_addr);
                chk("from_pf",   32'(from_pf),     32'(mdl_pf));
                chk("line_err",  32'(line_err),    32'(mdl_err));
                for (int i = 0; i < 16; i++) chk("line_data", line_data[i], mdl_line[i]);
            end
            if (exp_cv) chk("crit_word", crit_word, mdl_crit);
        end
    end

    // Miss served from the prefetch buffer; the caller has set pf_* to hit.
    task automatic pf_hit(input logic [31:0] addr, input bit hold, input logic [31:0] next);
        int w;
        w = int'(addr[5:2]);
        miss_req = 1'b1;
        miss_addr = addr;
        step();
        mdl_addr = {addr[31:6], 6'd0};
        mdl_pf = 1'b1;
        mdl_err = 1'b0;
        for (int i = 0; i < 16; i++) mdl_line[i] = pf_data[i];
        mdl_crit = pf_data[w];
        exp_lv = 1'b1;
        exp_cv = 1'b1;
        if (hold) miss_addr = next; else miss_req = 1'b0;
        step();
    endtask

    // Miss served over AXI. Beat b carries data_base+b; beat err_beat has
    // rresp=2. With abort set, reset is applied after nbeats beats instead of
    // finishing the burst.
    task automatic axi_refill(input logic [31:0] addr, input int ar_delay, input int gap,
                              input int nbeats, input int err_beat, input logic [31:0] data_base,
                              input bit abort, input bit hold, input logic [31:0] next);
        int w;
        logic [31:0] d;
        bit last;
        w = int'(addr[5:2]);
        miss_req = 1'b1;
        miss_addr = addr;
        step();
        mdl_addr = {addr[31:6], 6'd0};
        mdl_pf = 1'b0;
        mdl_err = 1'b0;
        exp_arvalid = 1'b1;
        exp_araddr = mdl_addr;
        repeat (ar_delay) step();
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        exp_arvalid = 1'b0;
        exp_araddr = 32'd0;
        exp_rready = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            repeat (gap) step();
            d = data_base + 32'(b);
            last = !abort && (b == nbeats - 1);
            axi.rvalid = 1'b1;
            axi.rdata = d;
            axi.rresp = (b == err_beat) ? 2'd2 : 2'd0;
            axi.rlast = last;
            step();
            axi.rvalid = 1'b0;
            axi.rlast = 1'b0;
            axi.rresp = 2'd0;
            mdl_line[b % 16] = d;
            if (b == err_beat) mdl_err = 1'b1;
            if ((b % 16) == w) begin
                mdl_crit = d;
                exp_cv = 1'b1;
            end
            if (last) begin
                exp_lv = 1'b1;
                exp_rready = 1'b0;
            end
        end
        if (abort) begin
            rst = 1'b0;
            miss_req = 1'b0;
            model_clear();
            #1;
            chk_all_zero("midreset");
            step();
            step();
            rst = 1'b1;
            step();
        end else begin
            if (hold) miss_addr = next; else miss_req = 1'b0;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        miss_req = 1'b0;
        miss_addr = 32'd0;
        pf_addr = 32'd0;
        pf_data = '0;
        pf_ready = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid = 1'b0;
        axi.rdata = 32'd0;
        axi.rresp = 2'd0;
        axi.rlast = 1'b0;
        axi.rid = 4'd0;
        model_clear();

        // Reset state, before any clock edge
        #3;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b1;
        chk_en = 1'b1;
        step();

        // Prefetch hit
        pf_ready = 1'b1;
        pf_addr = 32'hBFC0_0040;
        for (int i = 0; i < 16; i++) pf_data[i] = 32'(i);
        pf_hit(32'hBFC0_0048, 1'b0, 32'd0);
        chk("pf_crit_lit", crit_word, 32'd2);
        chk("pf_addr_lit", line_addr, 32'hBFC0_0040);
        chk("pf_from_lit", 32'(from_pf), 32'd1);
        chk("pf_data7_lit", line_data[7], 32'd7);

        // AXI path with delayed arready
        pf_ready = 1'b0;
        axi_refill(32'h0000_1234, 3, 0, 16, -1, 32'hA0, 1'b0, 1'b0, 32'd0);
        chk("axi_crit_lit", crit_word, 32'hAD);
        chk("axi_data15_lit", line_data[15], 32'hAF);
        chk("axi_addr_lit", line_addr, 32'h0000_1200);
        chk("axi_from_lit", 32'(from_pf), 32'd0);

        // Prefetch buffer valid but holding a different line
        pf_ready = 1'b1;
        pf_addr = 32'h0000_1240;
        axi_refill(32'h0000_1200, 0, 0, 16, -1, 32'h300, 1'b0, 1'b0, 32'd0);
        chk("mismatch_from_lit", 32'(from_pf), 32'd0);
        chk("mismatch_data0_lit", line_data[0], 32'h300);

        // Bubbles between beats and an error response on beat 5
        axi_refill(32'h4000_0010, 1, 2, 16, 5, 32'hC0, 1'b0, 1'b0, 32'd0);
        chk("err_lit", 32'(line_err), 32'd1);
        chk("bubble_crit_lit", crit_word, 32'hC4);
        axi_refill(32'h4000_0040, 0, 0, 16, -1, 32'hD0, 1'b0, 1'b0, 32'd0);
        chk("noerr_lit", 32'(line_err), 32'd0);

        // Early rlast: words 4..15 keep the previous line
        axi_refill(32'h0000_0080, 0, 0, 4, -1, 32'hE0, 1'b0, 1'b0, 32'd0);
        chk("early_data3_lit", line_data[3], 32'hE3);
        chk("early_data5_lit", line_data[5], 32'hD5);

        // Overlong burst: beats 16 and 17 overwrite words 0 and 1
        axi_refill(32'h0000_1004, 0, 0, 18, -1, 32'h700, 1'b0, 1'b0, 32'd0);
        chk("wrap_data0_lit", line_data[0], 32'h710);
        chk("wrap_data2_lit", line_data[2], 32'h702);
        chk("wrap_crit_lit", crit_word, 32'h711);

        // Reset after 7 beats, then a fresh refill
        axi_refill(32'h0000_3000, 1, 0, 7, -1, 32'h800, 1'b1, 1'b0, 32'd0);
        axi_refill(32'h0000_2000, 0, 0, 16, -1, 32'h900, 1'b0, 1'b0, 32'd0);
        chk("post_reset_data0_lit", line_data[0], 32'h900);
        chk("post_reset_addr_lit", line_addr, 32'h0000_2000);

        // Back-to-back: miss_req held through line_valid with a new address
        pf_ready = 1'b1;
        pf_addr = 32'h0000_7000;
        axi_refill(32'h0000_5000, 0, 0, 16, -1, 32'hF00, 1'b0, 1'b1, 32'h0000_6008);
        axi_refill(32'h0000_6008, 2, 1, 16, -1, 32'hF80, 1'b0, 1'b1, 32'h0000_7004);
        pf_hit(32'h0000_7004, 1'b0, 32'd0);
        chk("b2b_addr_lit", line_addr, 32'h0000_7000);
        chk("b2b_crit_lit", crit_word, 32'd1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
